// File: rtl/k_16_sqrt_sched.sv
// Round-robin scheduler sharing one approximate FP16 sqrt unit between NREQ requesters.
// Optional K16_SQRT_SPECIAL_EN: zero/negative/NaN/inf/subnormal operands bypass the unit.
module k_16_sqrt_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [15:0]          sq_in,
  output logic                 sq_en,
  input  logic [15:0]          sq_out,
  input  logic                 sq_done,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_data,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state_q;
  logic [15:0]     op_q;
  logic [15:0]     res_q;
  logic [IDW-1:0]  id_q;
  logic [IDW-1:0]  last_q;

  logic            gnt_vld_d;
  logic [IDW-1:0]  gnt_id_d;
  logic [15:0]     gnt_data_d;
  logic            hs_d;

`ifdef K16_SQRT_SPECIAL_EN
  // Returns {bypass, result}; bypass set when the answer is known without the unit.
  function automatic logic [16:0] classify(input logic [15:0] x);
    logic [4:0] e;
    logic [9:0] m;
    e = x[14:10];
    m = x[9:0];
    if (e == 5'd0 && m == 10'd0)       classify = {1'b1, x};
    else if (x[15])                    classify = {1'b1, 16'h7E00};
    else if (e == 5'd31 && m != 10'd0) classify = {1'b1, 16'h7E00};
    else if (e == 5'd31)               classify = {1'b1, 16'h7C00};
    else if (e == 5'd0)                classify = {1'b1, 16'h0000};
    else                               classify = {1'b0, x};
  endfunction

  logic [16:0] cls_d;
  assign cls_d = classify(gnt_data_d);
`endif

  // Rotating priority search starting just after the last granted requester.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_vld_d = 1'b0;
    gnt_id_d  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!gnt_vld_d && req_valid[idx]) begin
        gnt_vld_d = 1'b1;
        gnt_id_d  = IDW'(idx);
      end
    end
  end

  assign gnt_data_d = req_data[16*int'(gnt_id_d) +: 16];
  assign hs_d       = rst_n && (state_q == IDLE) && gnt_vld_d;
  assign req_ready  = hs_d ? (NREQ'(1) << gnt_id_d) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      res_q   <= '0;
      id_q    <= '0;
      last_q  <= IDW'(NREQ - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (hs_d) begin
            op_q   <= gnt_data_d;
            id_q   <= gnt_id_d;
            last_q <= gnt_id_d;
`ifdef K16_SQRT_SPECIAL_EN
            if (cls_d[16]) begin
              res_q   <= cls_d[15:0];
              state_q <= RESP;
            end else begin
              state_q <= ISSUE;
            end
`else
            state_q <= ISSUE;
`endif
          end
        end
        ISSUE: begin
          if (sq_done) begin
            res_q   <= sq_out;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sq_in     = op_q;
  assign sq_en     = (state_q == ISSUE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = res_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_k_16_sqrt_sched.sv
// Scoreboard bench for k_16_sqrt_sched: directed latency/arbitration cases plus random traffic.
module tb_k_16_sqrt_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [16*NREQ-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic [15:0]         sq_in;
  logic                sq_en;
  logic [15:0]         sq_out;
  logic                sq_done;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [15:0]         rsp_data;
  logic                busy;
  logic                done_gate;

  always #5 clk = ~clk;

  k_16_sqrt_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .sq_in(sq_in), .sq_en(sq_en), .sq_out(sq_out),
    .sq_done(sq_done), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  // Stand-in for the approximate sqrt unit: halve the exponent-biased word and re-bias.
  function automatic logic [15:0] unit_model(input logic [15:0] x);
    return (x >> 1) + 16'h1E10;
  endfunction

  function automatic logic [15:0] ref_result(input logic [15:0] x);
`ifdef K16_SQRT_SPECIAL_EN
    if (x[14:0] == 15'd0) return x;
    if (x[15]) return 16'h7E00;
    if (x[14:10] == 5'd31) return (x[9:0] != 10'd0) ? 16'h7E00 : 16'h7C00;
    if (x[14:10] == 5'd0) return 16'h0000;
`endif
    return unit_model(x);
  endfunction

  function automatic int predict(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  assign sq_out  = unit_model(sq_in);
  assign sq_done = sq_en & done_gate;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [15:0]    data;
  } rsp_t;

  rsp_t exp_q[$];
  int   model_last = NREQ - 1;
  int   total = 0;
  int   bad = 0;
  int   mg;
  rsp_t me;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  // Monitor: predicts each grant, queues the expected answer, and checks responses on accept.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_last = NREQ - 1;
    end else begin
      if (|req_ready) begin
        mg = predict(req_valid, model_last);
        check("grant", 32'(req_ready), (mg < 0) ? 32'd0 : (32'd1 << mg));
        if (mg >= 0) begin
          me.id   = IDW'(mg);
          me.data = ref_result(req_data[16*mg +: 16]);
          exp_q.push_back(me);
          model_last = mg;
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          me = exp_q.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(me.id));
          check("rsp_data", 32'(rsp_data), 32'(me.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_sq_en"}, 32'(sq_en), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_sq_in"}, 32'(sq_in), 32'd0);
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    tick();
    tick();
    check_all_zero("reset");
    req_valid = '0;
    rst_n     = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  logic [15:0] sp [6];
  logic [15:0] held;

  initial begin
    sp = '{16'h0000, 16'h8000, 16'hC000, 16'h7C00, 16'h7E01, 16'h0001};
    rst_n = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b1; done_gate = 1'b1;
    do_reset();

    // Single request latency
    req_valid = 4'b0001; req_data[15:0] = 16'h4400; #1;
    check("t1_ready", 32'(req_ready), 32'd1);
    tick(); req_valid = '0; #1;
    check("t1_sq_en", 32'(sq_en), 32'd1);
    check("t1_sq_in", 32'(sq_in), 32'h4400);
    check("t1_early_rsp", 32'(rsp_valid), 32'd0);
    tick(); #1;
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_rsp_id", 32'(rsp_id), 32'd0);
    check("t1_rsp_data", 32'(rsp_data), 32'h4010);
    check("t1_sq_en_off", 32'(sq_en), 32'd0);
    tick(); #1;
    check("t1_idle", 32'(busy), 32'd0);

    // All requesters valid, round-robin order 0,1,2,3,0
    do_reset();
    req_data = {16'h5000, 16'h4C00, 16'h4800, 16'h4400};
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      #1;
      check("rr_ready", 32'(req_ready), (k % 3 == 0) ? (32'd1 << ((k / 3) % 4)) : 32'd0);
      check("rr_rsp_valid", 32'(rsp_valid), 32'(k % 3 == 2));
      tick();
    end

    // Backpressure in RESP
    rsp_ready = 1'b0; #1;
    check("bp_ready", 32'(req_ready), 32'b0010);
    tick(); tick(); #1;
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_id", 32'(rsp_id), 32'd1);
      check("bp_data", 32'(rsp_data), 32'(ref_result(16'h4800)));
      check("bp_no_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1; req_valid = '0; #1;
    check("bp_release_valid", 32'(rsp_valid), 32'd1);
    tick(); #1;
    check("bp_after", 32'(rsp_valid), 32'd0);

    // Reset while in ISSUE
    req_valid = 4'b0010; #1;
    check("rst_grant", 32'(req_ready), 32'b0010);
    tick(); req_valid = '0; #1;
    check("rst_issue", 32'(sq_en), 32'd1);
    rst_n = 1'b0; req_valid = 4'b1111;
    tick();
    check_all_zero("midrst");
    rst_n = 1'b1; #1;
    check("rst_next_grant", 32'(req_ready), 32'b0001);
    tick(); req_valid = '0;
    tick(); #1;
    check("rst_next_rsp", 32'(rsp_valid), 32'd1);
    tick();

    // Special-operand handling
`ifdef K16_SQRT_SPECIAL_EN
    for (int k = 0; k < 3; k++) begin
      held = (k == 0) ? 16'hC000 : (k == 1) ? 16'h8000 : 16'h7C00;
      req_valid = 4'b0001; req_data[15:0] = held; #1;
      check("sp_ready", 32'(req_ready), 32'd1);
      tick(); req_valid = '0; #1;
      check("sp_no_sq_en", 32'(sq_en), 32'd0);
      check("sp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("sp_rsp_data", 32'(rsp_data),
            (k == 0) ? 32'h7E00 : (k == 1) ? 32'h8000 : 32'h7C00);
      tick(); #1;
      check("sp_done", 32'(rsp_valid), 32'd0);
    end
`else
    req_valid = 4'b0001; req_data[15:0] = 16'hC000; #1;
    check("neg_ready", 32'(req_ready), 32'd1);
    tick(); req_valid = '0; #1;
    check("neg_sq_en", 32'(sq_en), 32'd1);
    tick(); #1;
    check("neg_sq_en_once", 32'(sq_en), 32'd0);
    check("neg_rsp_valid", 32'(rsp_valid), 32'd1);
    check("neg_rsp_data", 32'(rsp_data), 32'h7E10);
    tick();
`endif

    // Random traffic with stalls and occasional reset
    for (int c = 0; c < 3000; c++) begin
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++)
        req_data[16*i +: 16] = ($urandom % 4 == 0) ? sp[$urandom % 6] : 16'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      done_gate = ($urandom % 3) != 0;
      rst_n     = ($urandom % 500) != 0;
      tick();
    end
    rst_n = 1'b1; req_valid = '0; rsp_ready = 1'b1; done_gate = 1'b1;
    for (int c = 0; c < 20 && (exp_q.size() != 0 || busy); c++) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/k_16_sqrt_sched.md
Name: k_16_sqrt_sched

Overview:
- Round-robin scheduler sharing one k_16_sqrt approximate half-precision square-root unit between NREQ requesters, e.g. k-means distance cores needing sqrt of squared distance.
- Accepts operands over per-requester valid/ready, issues one operand at a time to the sqrt datapath, captures the result and returns it on a single tagged response channel with backpressure.
- Sits between the distance-accumulation stage and cluster-assignment logic.

Parameters:
- NREQ, 4, number of requesters (2..16).
- IDW, 2, width of requester tag; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  per-requester operand valid.
- req_data  in  16*NREQ  FP16 operands; requester i at [16*i+15:16*i].
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- sq_in  out  16  operand to sqrt unit.
- sq_en  out  1  sqrt unit enable.
- sq_out  in  16  sqrt unit result.
- sq_done  in  1  sqrt unit result valid.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  requester index of response.
- rsp_data  out  16  FP16 result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low at posedge): state=IDLE, op_reg=0, id_reg=0, res_reg=0, last_grant=NREQ-1. All outputs 0: req_ready, sq_en, rsp_valid and busy low; sq_in, rsp_id and rsp_data 0. Reset mid-transaction discards the in-flight operand and result with no response.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Grant g is the first index with req_valid high, searching from last_grant+1 modulo NREQ upward.
  - req_ready[g] is asserted combinationally for that one cycle only; no other ready bit is high.
  - On the handshake: op_reg<=req_data[g], id_reg<=g, last_grant<=g, go to ISSUE.
  - With no valid request, stay in IDLE with all ready bits low.
- ISSUE:
  - sq_en=1, sq_in=op_reg.
  - When sq_done=1: res_reg<=sq_out, go to RESP.
  - While sq_done=0: hold in ISSUE indefinitely. The attached unit returns done=en, so this costs one cycle.
- RESP:
  - rsp_valid=1, rsp_id=id_reg, rsp_data=res_reg; all three held stable until rsp_ready.
  - On rsp_valid and rsp_ready: go to IDLE.
  - No new request is accepted while in RESP.
- sq_in is driven from op_reg in every state. sq_en is high only in ISSUE.
- Latency: handshake in cycle T, sq_en high in T+1, rsp_valid high from T+2. Peak throughput is 1 result per 3 cycles when rsp_ready is held high.
- Fairness: each continuously-valid requester is served within NREQ transactions.
- req_data of non-granted requesters is ignored. A requester may drop valid without penalty before it is granted.

Optional Feature:
- Macro: K16_SQRT_SPECIAL_EN.
- Defined: operands are classified at the IDLE handshake. Special cases skip ISSUE: res_reg is loaded directly, state goes IDLE->RESP, and the response appears in T+1. Cases:
  - exp=0 and mant=0 (±0): result equals the input.
  - sign=1 with nonzero magnitude: 16'h7E00.
  - exp=31 and mant!=0 (NaN): 16'h7E00.
  - +inf (16'h7C00): 16'h7C00.
  - Subnormal (exp=0, mant!=0): 16'h0000.
  - Normal positive operands use the sqrt unit as normal.
- Undefined: all operands go through ISSUE unchanged, and no classification logic is present.

Test Plan:
- Single request: req 0 sends 16'h4400 with the real unit attached -> req_ready[0] in T, sq_en in T+1, rsp_valid in T+2 with rsp_id=0 and rsp_data=16'h4010.
- All four requesters held valid with distinct operands and rsp_ready=1 -> grants in order 0,1,2,3,0; exactly one response per 3 cycles; ids match the operands.
- rsp_ready held low for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_data stable; req_ready stays 0; release yields exactly one accepted response.
- rst_n low in the cycle after grant (ISSUE) -> next cycle all outputs 0; no response for that operand; the next grant goes to requester 0 if it is valid.
- With K16_SQRT_SPECIAL_EN defined: 16'hC000 gives rsp_data=16'h7E00 in T+1 with sq_en never high; 16'h8000 gives 16'h8000; 16'h7C00 gives 16'h7C00.
- With K16_SQRT_SPECIAL_EN undefined: 16'hC000 passes through ISSUE; sq_en is high for one cycle and rsp_data equals sq_out.
